sipo_rx_controller: RTL and testbench

//   Frame-level sequencer for the 8-bit SIPO deserializer path. Detects a start
//   bit on the serial line, shifts DATA_WIDTH bits LSB-first, checks the stop
//   bit, then hands the byte to the consumer over a valid/ready handshake.

---
 rtl/sipo_rx_controller_if.sv | 36 +++
 rtl/sipo_rx_controller.sv | 145 ++++++++++++++
 tb/tb_sipo_rx_controller.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_controller_if.sv
// Serial-receive bus: serial line in, message valid/ready handshake out.
// master = receiver side, slave = line driver / consumer side.
interface sipo_rx_controller_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  serialIn;
  logic                  messageReady;
  logic [DATA_WIDTH-1:0] message;
  logic                  messageValid;
  logic                  busy;
  logic                  frameError;
  logic                  overrun;
  logic                  parityError;

  modport master (
    input  serialIn,
    input  messageReady,
    output message,
    output messageValid,
    output busy,
    output frameError,
    output overrun,
    output parityError
  );

  modport slave (
    output serialIn,
    output messageReady,
    input  message,
    input  messageValid,
    input  busy,
    input  frameError,
    input  overrun,
    input  parityError
  );
endinterface

// File: rtl/sipo_rx_controller.sv
// Frame-aligned SIPO receiver: start/data(LSB first)/[parity]/stop, then
// valid/ready delivery. Ports: clock, reset (async high), bus (master).
// Optional even parity bit enabled by defining SIPO_RX_PARITY_EN.
module sipo_rx_controller #(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input logic                   clock,
  input logic                   reset,
  sipo_rx_controller_if.master  bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] msg_q, msg_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic [DATA_WIDTH:0]   shift_cat;
  logic                  good;
`ifdef SIPO_RX_PARITY_EN
  logic                  perr_q, perr_d;
  logic                  par_bad_q, par_bad_d;
`endif

  // New bit enters at the MSB; after DATA_WIDTH shifts the first bit is in [0].
  assign shift_cat = {bus.serialIn, shreg_q};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    msg_d     = msg_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    good      = 1'b0;
`ifdef SIPO_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    if (valid_q && bus.messageReady) valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.serialIn == ~IDLE_LEVEL) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        shreg_d   = shift_cat[DATA_WIDTH:1];
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST) begin
`ifdef SIPO_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef SIPO_RX_PARITY_EN
        // Even parity: data bits plus parity bit must XOR to zero.
        par_bad_d = ^shift_cat;
`endif
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        if (bus.serialIn != IDLE_LEVEL) begin
          ferr_d = 1'b1;
        end
`ifdef SIPO_RX_PARITY_EN
        else if (par_bad_q) begin
          perr_d = 1'b1;
        end
`endif
        else begin
          good = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A consume on the delivery edge frees the buffer for the new byte.
    if (good) begin
      if (!valid_q || bus.messageReady) begin
        msg_d   = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      msg_q     <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      msg_q     <= msg_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef SIPO_RX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
    end
  end
  assign bus.parityError = perr_q;
`else
  assign bus.parityError = 1'b0;
`endif

  assign bus.message      = msg_q;
  assign bus.messageValid = valid_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.frameError   = ferr_q;
  assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_sipo_rx_controller.sv
// Directed bench for sipo_rx_controller: reset, single frame, overrun,
// framing error, async reset abort, same-edge handoff, optional parity.
module tb_sipo_rx_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt;

`ifdef SIPO_RX_PARITY_EN
  localparam int FRAME_BUSY = 10;
`else
  localparam int FRAME_BUSY = 9;
`endif

  sipo_rx_controller_if #(.DATA_WIDTH(8)) bus ();

  sipo_rx_controller #(
    .DATA_WIDTH(8),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clock = ~clock;

  // Drive one serial bit, let one edge sample it, settle just after it.
  task automatic step(input logic b);
    bus.serialIn = b;
    @(posedge clock);
    #1;
  endtask

  // Start bit, data LSB first, optional parity; counts busy cycles.
  task automatic send_data(input logic [7:0] d, input logic bad_par);
    busy_cnt = 0;
    step(1'b0);
    if (bus.busy) busy_cnt++;
    for (int i = 0; i < 8; i++) begin
      step(d[i]);
      if (bus.busy) busy_cnt++;
    end
`ifdef SIPO_RX_PARITY_EN
    step((^d) ^ bad_par);
    if (bus.busy) busy_cnt++;
`else
    if (bad_par) busy_cnt = busy_cnt;
`endif
  endtask

  task automatic test_reset;
    bus.serialIn     = 1'b1;
    bus.messageReady = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    step(1'b1);
    checks++;
    if ({bus.message, bus.messageValid, bus.busy, bus.frameError,
         bus.overrun, bus.parityError} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got msg=%h v=%b busy=%b fe=%b ov=%b pe=%b, expected all 0",
               bus.message, bus.messageValid, bus.busy, bus.frameError,
               bus.overrun, bus.parityError);
    end
  endtask

  task automatic test_single_frame;
    int vcnt;
    bus.messageReady = 1'b1;
    send_data(8'hA5, 1'b0);
    checks++;
    if (bus.messageValid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: got %b expected 0", bus.messageValid);
    end
    step(1'b1);
    checks++;
    if (bus.message !== 8'hA5 || bus.messageValid !== 1'b1) begin
      errors++;
      $display("FAIL a5_deliver: got msg=%h v=%b expected msg=a5 v=1",
               bus.message, bus.messageValid);
    end
    checks++;
    if (busy_cnt !== FRAME_BUSY || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL a5_busy: got cycles=%0d busy_now=%b expected %0d and 0",
               busy_cnt, bus.busy, FRAME_BUSY);
    end
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      if (bus.messageValid) vcnt++;
    end
    checks++;
    if (vcnt !== 0 || bus.parityError !== 1'b0 || bus.frameError !== 1'b0) begin
      errors++;
      $display("FAIL a5_valid_once: got extra_valid=%0d pe=%b fe=%b expected 0 0 0",
               vcnt, bus.parityError, bus.frameError);
    end
  endtask

  task automatic test_back_to_back;
    bus.messageReady = 1'b0;
    send_data(8'h3C, 1'b0);
    step(1'b1);
    checks++;
    if (bus.message !== 8'h3C || bus.messageValid !== 1'b1 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got msg=%h v=%b ov=%b expected 3c 1 0",
               bus.message, bus.messageValid, bus.overrun);
    end
    send_data(8'hC3, 1'b0);
    step(1'b1);
    checks++;
    if (bus.message !== 8'h3C || bus.messageValid !== 1'b1 || bus.overrun !== 1'b1
        || bus.frameError !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overrun: got msg=%h v=%b ov=%b fe=%b expected 3c 1 1 0",
               bus.message, bus.messageValid, bus.overrun, bus.frameError);
    end
    step(1'b1);
    checks++;
    if (bus.overrun !== 1'b0 || bus.messageValid !== 1'b1 || bus.message !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_ov_pulse: got ov=%b v=%b msg=%h expected 0 1 3c",
               bus.overrun, bus.messageValid, bus.message);
    end
    bus.messageReady = 1'b1;
    step(1'b1);
    checks++;
    if (bus.messageValid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_consume: got v=%b expected 0", bus.messageValid);
    end
  endtask

  task automatic test_frame_error;
    bus.messageReady = 1'b1;
    send_data(8'h81, 1'b0);
    step(1'b0);
    checks++;
    if (bus.frameError !== 1'b1 || bus.messageValid !== 1'b0 || bus.busy !== 1'b0
        || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL fe_pulse: got fe=%b v=%b busy=%b ov=%b expected 1 0 0 0",
               bus.frameError, bus.messageValid, bus.busy, bus.overrun);
    end
    step(1'b1);
    checks++;
    if (bus.frameError !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL fe_one_cycle: got fe=%b busy=%b expected 0 0",
               bus.frameError, bus.busy);
    end
    send_data(8'h18, 1'b0);
    step(1'b1);
    checks++;
    if (bus.message !== 8'h18 || bus.messageValid !== 1'b1) begin
      errors++;
      $display("FAIL fe_recover: got msg=%h v=%b expected 18 1",
               bus.message, bus.messageValid);
    end
  endtask

  task automatic test_async_reset;
    int bad;
    bus.messageReady = 1'b0;
    step(1'b1);
    step(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.message, bus.messageValid, bus.busy, bus.frameError,
         bus.overrun, bus.parityError} !== 13'h0) begin
      errors++;
      $display("FAIL async_reset: got msg=%h v=%b busy=%b fe=%b ov=%b, expected all 0",
               bus.message, bus.messageValid, bus.busy, bus.frameError, bus.overrun);
    end
    step(1'b1);
    step(1'b1);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1);
      if (bus.messageValid || bus.busy || bus.frameError || bus.overrun) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d active cycles expected 0", bad);
    end
    bus.messageReady = 1'b1;
    send_data(8'h55, 1'b0);
    step(1'b1);
    checks++;
    if (bus.message !== 8'h55 || bus.messageValid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_55: got msg=%h v=%b expected 55 1",
               bus.message, bus.messageValid);
    end
    step(1'b1);
  endtask

  task automatic test_same_edge_handoff;
    bus.messageReady = 1'b0;
    send_data(8'h11, 1'b0);
    step(1'b1);
    checks++;
    if (bus.message !== 8'h11 || bus.messageValid !== 1'b1) begin
      errors++;
      $display("FAIL handoff_first: got msg=%h v=%b expected 11 1",
               bus.message, bus.messageValid);
    end
    send_data(8'h22, 1'b0);
    bus.messageReady = 1'b1;
    step(1'b1);
    checks++;
    if (bus.message !== 8'h22 || bus.messageValid !== 1'b1 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL handoff_same_edge: got msg=%h v=%b ov=%b expected 22 1 0",
               bus.message, bus.messageValid, bus.overrun);
    end
    step(1'b1);
    checks++;
    if (bus.messageValid !== 1'b0 || bus.message !== 8'h22) begin
      errors++;
      $display("FAIL handoff_consume: got v=%b msg=%h expected 0 22",
               bus.messageValid, bus.message);
    end
  endtask

`ifdef SIPO_RX_PARITY_EN
  task automatic test_parity;
    bus.messageReady = 1'b1;
    send_data(8'h07, 1'b0);
    step(1'b1);
    checks++;
    if (bus.message !== 8'h07 || bus.messageValid !== 1'b1 || bus.parityError !== 1'b0) begin
      errors++;
      $display("FAIL parity_good: got msg=%h v=%b pe=%b expected 07 1 0",
               bus.message, bus.messageValid, bus.parityError);
    end
    step(1'b1);
    send_data(8'h07, 1'b1);
    step(1'b1);
    checks++;
    if (bus.parityError !== 1'b1 || bus.messageValid !== 1'b0 || bus.overrun !== 1'b0
        || bus.frameError !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad: got pe=%b v=%b ov=%b fe=%b expected 1 0 0 0",
               bus.parityError, bus.messageValid, bus.overrun, bus.frameError);
    end
    step(1'b1);
    checks++;
    if (bus.parityError !== 1'b0) begin
      errors++;
      $display("FAIL parity_pulse: got pe=%b expected 0", bus.parityError);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_error();
    test_async_reset();
    test_same_edge_handoff();
`ifdef SIPO_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
